register_dump_reader: RTL and testbench

- Debug-side reader for the register file. On request, it walks every architectural register through one read port (readAddress/readData).
- It streams each value out over a valid/ready handshake, tagged with its register index.
- Sits beside the core's register file on a spare read port. Feeds a debug link (UART/JTAG shim) that observes core state, e.g. register31Output-style result checking extended to all 32 registers.
- Read port is combinational: readData reflects readAddress in the same cycle.

---
 rtl/register_dump_reader.sv | 119 +++++++++++
 tb/tb_register_dump_reader.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/register_dump_reader.sv
// Walks every register through one combinational read port and streams each value out over valid/ready.
// Optional feature: define REGISTER_DUMP_CHECKSUM_EN to append an XOR checksum word after the last register.
module register_dump_reader #(
   parameter int REG_COUNT  = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  dumpStart,
   output logic                  busy,
   output logic [ADDR_WIDTH-1:0] readAddress,
   input  logic [DATA_WIDTH-1:0] readData,
   output logic [DATA_WIDTH-1:0] dataOut,
   output logic [ADDR_WIDTH-1:0] dataAddr,
   output logic                  dataValid,
   input  logic                  dataReady,
   output logic                  dataIsChecksum,
   output logic                  dumpDone
);

   localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = ADDR_WIDTH'(REG_COUNT - 1);

`ifdef REGISTER_DUMP_CHECKSUM_EN
   typedef enum logic [2:0] {IDLE, LOAD, PRESENT, CHECKSUM, DONE} state_t;
`else
   typedef enum logic [2:0] {IDLE, LOAD, PRESENT, DONE} state_t;
`endif

   state_t                state;
   logic [ADDR_WIDTH-1:0] index;

`ifdef REGISTER_DUMP_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] checksum;
   logic                  isChecksumReg;
   assign dataIsChecksum = isChecksumReg;
`else
   assign dataIsChecksum = 1'b0;
`endif

   // The read port is combinational, so the address must follow index without a register stage.
   assign readAddress = index;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         index     <= '0;
         dataOut   <= '0;
         dataAddr  <= '0;
         dataValid <= 1'b0;
         busy      <= 1'b0;
         dumpDone  <= 1'b0;
`ifdef REGISTER_DUMP_CHECKSUM_EN
         checksum      <= '0;
         isChecksumReg <= 1'b0;
`endif
      end else begin
         dumpDone <= 1'b0;
         case (state)
            IDLE: begin
               if (dumpStart) begin
                  index <= '0;
                  busy  <= 1'b1;
                  state <= LOAD;
`ifdef REGISTER_DUMP_CHECKSUM_EN
                  checksum <= '0;
`endif
               end
            end
            LOAD: begin
               dataOut   <= readData;
               dataAddr  <= index;
               dataValid <= 1'b1;
               state     <= PRESENT;
`ifdef REGISTER_DUMP_CHECKSUM_EN
               checksum <= checksum ^ readData;
`endif
            end
            PRESENT: begin
               if (dataReady) begin
                  dataValid <= 1'b0;
                  if (index == LAST_INDEX) begin
`ifdef REGISTER_DUMP_CHECKSUM_EN
                     // The checksum already holds the final word, captured in the last LOAD.
                     dataOut       <= checksum;
                     dataAddr      <= '0;
                     dataValid     <= 1'b1;
                     isChecksumReg <= 1'b1;
                     state         <= CHECKSUM;
`else
                     dumpDone <= 1'b1;
                     state    <= DONE;
`endif
                  end else begin
                     index <= index + 1'b1;
                     state <= LOAD;
                  end
               end
            end
`ifdef REGISTER_DUMP_CHECKSUM_EN
            CHECKSUM: begin
               if (dataReady) begin
                  dataValid     <= 1'b0;
                  isChecksumReg <= 1'b0;
                  dumpDone      <= 1'b1;
                  state         <= DONE;
               end
            end
`endif
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_register_dump_reader.sv
// Self-checking bench for register_dump_reader: a register-file array, a consumer with stalls and
// random back-pressure, and a word-sequence model that predicts values, addresses, checksum and timing.
module tb_register_dump_reader;

   localparam int REG_COUNT  = 32;
   localparam int ADDR_WIDTH = 5;
   localparam int DATA_WIDTH = 32;
`ifdef REGISTER_DUMP_CHECKSUM_EN
   localparam int CK_WORDS = 1;
`else
   localparam int CK_WORDS = 0;
`endif

   logic                  clock = 1'b0;
   logic                  reset = 1'b0;
   logic                  dumpStart = 1'b0;
   logic                  dataReady = 1'b0;
   logic                  busy;
   logic                  dataValid;
   logic                  dataIsChecksum;
   logic                  dumpDone;
   logic [ADDR_WIDTH-1:0] readAddress;
   logic [ADDR_WIDTH-1:0] dataAddr;
   logic [DATA_WIDTH-1:0] readData;
   logic [DATA_WIDTH-1:0] dataOut;
   logic [DATA_WIDTH-1:0] regs [REG_COUNT];

   int compareCount  = 0;
   int mismatchCount = 0;

   register_dump_reader #(
      .REG_COUNT(REG_COUNT),
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH)
   ) dut (
      .clock(clock),
      .reset(reset),
      .dumpStart(dumpStart),
      .busy(busy),
      .readAddress(readAddress),
      .readData(readData),
      .dataOut(dataOut),
      .dataAddr(dataAddr),
      .dataValid(dataValid),
      .dataReady(dataReady),
      .dataIsChecksum(dataIsChecksum),
      .dumpDone(dumpDone)
   );

   assign readData = regs[readAddress];

   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Runs one dump as the consumer; the model expects words 0..REG_COUNT-1 (plus checksum) in order.
   task automatic applyStimulus(input int stallAddr, input int stallLen, input bit randomReady,
                                input int pulseAt, input int abortAt, input bit writeDuring);
      int expAddr = 0;
      int words = 0;
      int dones = 0;
      int busyCycles = 0;
      int stallCycles = 0;
      int stallLeft = stallLen;
      int lastAccept = -1;
      int cyc = 0;
      bit newWord = 1'b1;
      bit finished = 1'b0;
      bit heldLow = 1'b0;
      bit pulsed = 1'b0;
      logic [DATA_WIDTH-1:0] xorSum = '0;
      dumpStart = 1'b1;
      dataReady = 1'b1;
      while (!finished && cyc < 4000) begin
         @(posedge clock);
         @(negedge clock);
         if (cyc == 0) checkOutput("busy_after_start", 64'(busy), 64'd1);
         dumpStart = 1'b0;
         if (!pulsed && pulseAt >= 0 && dataValid && expAddr == pulseAt) begin
            dumpStart = 1'b1;
            pulsed = 1'b1;
         end
         if (heldLow) checkOutput("stall_valid_held", 64'(dataValid), 64'd1);
         heldLow = 1'b0;
         if (busy) busyCycles++;
         if (dumpDone) begin
            dones++;
            checkOutput("done_timing", 64'(cyc), 64'(lastAccept + 1));
            checkOutput("done_busy", 64'(busy), 64'd1);
            finished = 1'b1;
         end else if (dataValid) begin
            if (abortAt == expAddr) begin
               reset = 1'b0;
               #1;
               checkOutput("abort_valid", 64'(dataValid), 64'd0);
               checkOutput("abort_busy", 64'(busy), 64'd0);
               checkOutput("abort_addr", 64'(dataAddr), 64'd0);
               checkOutput("abort_done", 64'(dumpDone), 64'd0);
               @(negedge clock);
               checkOutput("abort_no_done", 64'(dumpDone), 64'd0);
               reset = 1'b1;
               return;
            end
            if (newWord) begin
               checkOutput("word_gap", 64'(cyc - lastAccept), (expAddr == REG_COUNT) ? 64'd1 : 64'd2);
               newWord = 1'b0;
            end
            if (expAddr < REG_COUNT) begin
               checkOutput("word_data", 64'(dataOut), 64'(regs[expAddr]));
               checkOutput("word_addr", 64'(dataAddr), 64'(expAddr));
               checkOutput("word_flag", 64'(dataIsChecksum), 64'd0);
            end else begin
               checkOutput("ck_data", 64'(dataOut), 64'(xorSum));
               checkOutput("ck_addr", 64'(dataAddr), 64'd0);
               checkOutput("ck_flag", 64'(dataIsChecksum), 64'd1);
            end
            if (stallAddr == expAddr && stallLeft > 0) begin
               dataReady = 1'b0;
               stallLeft--;
            end else begin
               dataReady = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (!dataReady) begin
               stallCycles++;
               heldLow = 1'b1;
            end else begin
               if (expAddr < REG_COUNT) xorSum ^= regs[expAddr];
               words++;
               expAddr++;
               lastAccept = cyc;
               newWord = 1'b1;
               if (writeDuring && expAddr < REG_COUNT)
                  regs[$urandom_range(expAddr, REG_COUNT - 1)] = $urandom;
            end
         end else if (busy) begin
            checkOutput("load_addr", 64'(readAddress), 64'(expAddr));
         end
         cyc++;
      end
      checkOutput("timeout", 64'(finished), 64'd1);
      checkOutput("word_count", 64'(words), 64'(REG_COUNT + CK_WORDS));
      checkOutput("done_count", 64'(dones), 64'd1);
      checkOutput("busy_cycles", 64'(busyCycles), 64'(2 * REG_COUNT + 1 + CK_WORDS + stallCycles));
      @(negedge clock);
      checkOutput("idle_busy", 64'(busy), 64'd0);
      checkOutput("idle_done", 64'(dumpDone), 64'd0);
   endtask

   initial begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] = 32'hA500_0000 + 32'(i);
      reset = 1'b0;
      dumpStart = 1'b1;
      repeat (3) @(negedge clock);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_valid", 64'(dataValid), 64'd0);
      checkOutput("rst_data", 64'(dataOut), 64'd0);
      checkOutput("rst_addr", 64'(dataAddr), 64'd0);
      checkOutput("rst_raddr", 64'(readAddress), 64'd0);
      checkOutput("rst_done", 64'(dumpDone), 64'd0);
      checkOutput("rst_flag", 64'(dataIsChecksum), 64'd0);
      reset = 1'b1;
      applyStimulus(-1, 0, 1'b0, -1, -1, 1'b0);
      applyStimulus(3, 10, 1'b0, -1, -1, 1'b0);
      applyStimulus(-1, 0, 1'b0, -1, 7, 1'b0);
      applyStimulus(-1, 0, 1'b0, -1, -1, 1'b0);
      applyStimulus(-1, 0, 1'b0, 12, -1, 1'b0);
      for (int i = 0; i < REG_COUNT; i++) regs[i] = 32'(i);
      applyStimulus(-1, 0, 1'b0, -1, -1, 1'b0);
      regs[5] = 32'hFFFF_0000;
      applyStimulus(-1, 0, 1'b0, -1, -1, 1'b0);
      for (int n = 0; n < 4; n++) begin
         for (int i = 0; i < REG_COUNT; i++) regs[i] = $urandom;
         applyStimulus(int'($urandom_range(0, REG_COUNT - 1)), int'($urandom_range(1, 5)),
                       1'b1, -1, -1, 1'b1);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
